// File: rtl/alu_unit.sv
// Arithmetic stage fed by the B register and accumulator: ADD/SUB/PASS in one
// execute cycle, MUL as a WIDTH-iteration shift-add, result held and bus-driven on demand.
module alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             out_enable,
    output logic             busy,
    output logic             done,
    output logic             carry_flag,
    output logic             zero_flag,
    inout  wire  [WIDTH-1:0] w_bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_zero;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH:0]     w_exec_res;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_bus_en;

    // Single-cycle datapath; carry out of SUB is the inverted borrow.
    always_comb begin
        w_exec_res = {(WIDTH+1){1'b0}};
        case (r_op)
            2'b00:   w_exec_res = {1'b0, r_a} + {1'b0, r_b};
            2'b01:   w_exec_res = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
            2'b11:   w_exec_res = {1'b0, r_b};
            default: w_exec_res = {(WIDTH+1){1'b0}};
        endcase
    end

    // One shift-add step: multiplier is B, multiplicand is A.
    always_comb begin
        w_addend = {(2*WIDTH){1'b0}};
        if (r_b[r_cnt]) begin
            w_addend = {{WIDTH{1'b0}}, r_a} << r_cnt;
        end else begin
            w_addend = {(2*WIDTH){1'b0}};
        end
        w_prod_next = r_prod + w_addend;
    end

    // Control FSM with operand capture and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_op     <= 2'b00;
            r_cnt    <= {CW{1'b0}};
            r_prod   <= {(2*WIDTH){1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= acc_in;
                        r_b    <= b_in;
                        r_op   <= op;
                        r_cnt  <= {CW{1'b0}};
                        r_prod <= {(2*WIDTH){1'b0}};
                        r_busy <= 1'b1;
                        r_state <= (op == 2'b10) ? S_MUL : S_EXEC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_result <= w_exec_res[WIDTH-1:0];
                    r_carry  <= (r_op == 2'b11) ? 1'b0 : w_exec_res[WIDTH];
                    r_zero   <= (w_exec_res[WIDTH-1:0] == {WIDTH{1'b0}});
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_MUL: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == LAST_ITER) begin
                        r_result <= w_prod_next[WIDTH-1:0];
                        r_carry  <= |w_prod_next[2*WIDTH-1:WIDTH];
                        r_zero   <= (w_prod_next[WIDTH-1:0] == {WIDTH{1'b0}});
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_state  <= S_MUL;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;

    // Bus drive ignores FSM state so the last completed result stays visible while busy.
    assign w_bus_en = ~out_enable & ~reset;
    assign w_bus    = w_bus_en ? r_result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit; the bus carries a pull-up so an
// undriven bus reads 0xFF.
module tb_alu_unit;

    logic       clk;
    logic       reset;
    logic [7:0] acc_in;
    logic [7:0] b_in;
    logic [1:0] op;
    logic       start;
    logic       out_enable;
    logic       busy;
    logic       done;
    logic       carry_flag;
    logic       zero_flag;
    wire  [7:0] bus;

    pullup (bus);

    int checks = 0;
    int errors = 0;

    alu_unit #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .acc_in(acc_in), .b_in(b_in), .op(op),
        .start(start), .out_enable(out_enable), .busy(busy), .done(done),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .w_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command at a negedge; it is sampled at the following posedge (edge k).
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        @(negedge clk);
        acc_in = a; b_in = b; op = o; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; out_enable = 1'b0;
        acc_in = 8'h00; b_in = 8'h00; op = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b c=%b z=%b, required all 0", busy, done, carry_flag, zero_flag);
        end
        checks++;
        if (bus !== 8'hFF) begin
            errors++;
            $display("FAIL reset_bus_hiz: bus=%h, required FF (undriven)", bus);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus !== 8'h00) begin
            errors++;
            $display("FAIL reset_result: bus=%h, required 00", bus);
        end
    endtask

    task automatic test_add;
        issue(8'h2C, 8'h1D, 2'b00);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL add_busy: busy=%b done=%b, required 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus !== 8'h49 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
            errors++;
            $display("FAIL add_result: done=%b busy=%b bus=%h c=%b z=%b, required 1 0 49 0 0",
                     done, busy, bus, carry_flag, zero_flag);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL add_done_pulse: done=%b, required 0", done);
        end
    endtask

    task automatic test_bus_enable;
        out_enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus !== 8'hFF) begin
            errors++;
            $display("FAIL bus_disabled: bus=%h, required FF (undriven)", bus);
        end
        out_enable = 1'b0;
        #1;
        checks++;
        if (bus !== 8'h49) begin
            errors++;
            $display("FAIL bus_enabled: bus=%h, required 49", bus);
        end
    endtask

    // MUL 0x0C x 0x0B with an ignored ADD command and operand changes mid-run.
    task automatic test_mul;
        int done_count;
        done_count = 0;
        issue(8'h0C, 8'h0B, 2'b10);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) begin
                acc_in = 8'hFF; b_in = 8'hFF; op = 2'b00; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) done_count++;
            checks++;
            if (busy !== 1'b1 || bus !== 8'h49) begin
                errors++;
                $display("FAIL mul_busy_cycle%0d: busy=%b bus=%h, required 1 49", i, busy, bus);
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus !== 8'h84 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
            errors++;
            $display("FAIL mul_result: done=%b busy=%b bus=%h c=%b z=%b, required 1 0 84 0 0",
                     done, busy, bus, carry_flag, zero_flag);
        end
        if (done === 1'b1) done_count++;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) done_count++;
        end
        checks++;
        if (done_count != 1 || busy !== 1'b0 || bus !== 8'h84) begin
            errors++;
            $display("FAIL mul_ignore_start: done pulses=%0d busy=%b bus=%h, required 1 0 84", done_count, busy, bus);
        end
    endtask

    task automatic test_arith;
        logic [7:0] va [4] = '{8'hFF, 8'h05, 8'h07, 8'h12};
        logic [7:0] vb [4] = '{8'h01, 8'h07, 8'h07, 8'h3C};
        logic [1:0] vo [4] = '{2'b00, 2'b01, 2'b01, 2'b11};
        logic [7:0] er [4] = '{8'h00, 8'hFE, 8'h00, 8'h3C};
        logic       ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       ez [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], vo[i]);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || bus !== er[i] || carry_flag !== ec[i] || zero_flag !== ez[i]) begin
                errors++;
                $display("FAIL arith_vec%0d: done=%b bus=%h c=%b z=%b, required 1 %h %b %b",
                         i, done, bus, carry_flag, zero_flag, er[i], ec[i], ez[i]);
            end
        end
    endtask

    task automatic test_mul_overflow;
        issue(8'h20, 8'h10, 2'b10);
        repeat (9) @(negedge clk);
        checks++;
        if (done !== 1'b1 || bus !== 8'h00 || carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL mul_overflow: done=%b bus=%h c=%b z=%b, required 1 00 1 1",
                     done, bus, carry_flag, zero_flag);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul;
        int done_count;
        done_count = 0;
        issue(8'h0C, 8'h0B, 2'b10);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || carry_flag !== 1'b0 || zero_flag !== 1'b0 || bus !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_mul: busy=%b done=%b c=%b z=%b bus=%h, required 0 0 0 0 FF",
                     busy, done, carry_flag, zero_flag, bus);
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_count++;
        end
        checks++;
        if (done_count != 0 || bus !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: busy/done cycles=%0d bus=%h, required 0 00", done_count, bus);
        end
    endtask

    task automatic test_back_to_back;
        issue(8'h2C, 8'h1D, 2'b00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || bus !== 8'h49) begin
            errors++;
            $display("FAIL b2b_first: done=%b bus=%h, required 1 49", done, bus);
        end
        acc_in = 8'h07; b_in = 8'h07; op = 2'b01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || bus !== 8'h00 || carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: done=%b bus=%h c=%b z=%b, required 1 00 1 1",
                     done, bus, carry_flag, zero_flag);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_bus_enable();
        test_mul();
        test_arith();
        test_mul_overflow();
        test_reset_mid_mul();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

Arithmetic stage downstream of the B register: consumes the B register's output and the accumulator's output, executes one operation per `start` command, and holds the result plus carry/zero flags in internal registers. ADD, SUB and PASS complete in one execute cycle. MUL runs as an 8-iteration shift-add sequence. The held result is driven onto the shared bidirectional bus only when enabled; otherwise the bus is left at high-Z.

## Interface
Parameters:
- `WIDTH`, 8: data width of operands, result and bus.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `acc_in` input WIDTH: accumulator operand.
- `b_in` input WIDTH: B register operand.
- `op` input 2: operation code. 00 ADD, 01 SUB, 10 MUL, 11 PASS (result = B).
- `start` input 1: active-high command; sampled only in IDLE.
- `out_enable` input 1: active-low; when 0, the result register drives `w_bus`.
- `busy` output 1: high while in EXEC or MUL.
- `done` output 1: one-cycle pulse; high in the cycle after the result register updates.
- `carry_flag` output 1: registered carry.
- `zero_flag` output 1: registered zero.
- `w_bus` inout WIDTH: shared bus. Driven with the result register when `out_enable`=0 and `reset`=0; high-Z otherwise.

## Operation
- States:
  - IDLE: `busy`=0.
  - EXEC: single cycle, used by ADD/SUB/PASS.
  - MUL: 8 iterations.
- IDLE with `start`=1: latch `acc_in`, `b_in` and `op` into operand registers.
  - `op`=10 → MUL, with iteration counter = 0 and 2·WIDTH partial product = 0.
  - Any other `op` → EXEC.
- IDLE with `start`=0: stay in IDLE.
- EXEC (one edge), then → IDLE; `done`=1 for one cycle.
  - ADD: WIDTH+1-bit sum A+B. Result = low WIDTH bits; carry = MSB.
  - SUB: A + ~B + 1 computed at WIDTH+1 bits. Result = low bits; carry = MSB. Carry=1 means no borrow (A ≥ B unsigned).
  - PASS: result = B; carry = 0.
  - zero_flag = (result == 0) for all ops.
- MUL: each edge, if multiplier bit[counter] = 1, add multiplicand << counter to the partial product; counter increments.
  - After the edge with counter = WIDTH−1: result = product[WIDTH−1:0], carry = |product[2·WIDTH−1:WIDTH], zero = (result == 0).
  - Then → IDLE; `done`=1 next cycle.
- The result register and flags change only at operation completion. They hold their previous values while busy.
- `start` while busy is ignored; no queuing.
- `acc_in` and `b_in` changing after the start edge do not affect the operation in progress.
- The bus drive is independent of state: it drives the last completed result even while busy.

## Timing
- Reset values: state IDLE; result 0x00; `carry_flag`=0; `zero_flag`=0; `busy`=0; `done`=0; counter 0; `w_bus` high-Z.
- Reset mid-operation aborts the operation. Next cycle all registers hold their reset values, with no `done` pulse. Reset has priority over `start`.
- ADD/SUB/PASS, start sampled at edge k:
  - `busy`=1 from k to k+1.
  - Result and flags update at edge k+1.
  - `done`=1 in the cycle after k+1.
- MUL, start sampled at edge k:
  - Iterations occur at edges k+1 through k+8.
  - Result and flags update at edge k+8.
  - `done`=1 after k+8.
  - `busy` falls at k+8.
- Back-to-back: `start`=1 in the same cycle `done`=1 is accepted. The FSM is in IDLE in that cycle.
- `w_bus` drive is combinational from `out_enable` and the result register; there is no extra cycle.

## Test plan
- ADD, A=0x2C, B=0x1D, start pulse → result 0x49, carry 0, zero 0; `done` exactly one cycle, 2 edges after start.
- ADD 0xFF+0x01 → 0x00, carry 1, zero 1. SUB 0x05−0x07 → 0xFE, carry 0, zero 0. SUB 0x07−0x07 → 0x00, carry 1, zero 1.
- MUL 0x0C×0x0B → 0x84, carry 0, `busy` high for 8 cycles, `done` after edge k+8. MUL 0x20×0x10 → 0x00, carry 1, zero 1.
- During MUL, pulse `start` with op=ADD and change `acc_in`/`b_in` → ignored; MUL result unchanged; only one `done` pulse.
- Assert `reset` at iteration 4 of MUL → next cycle `busy`=0, result 0x00, flags 0, no `done`, `w_bus` high-Z.
- After ADD → 0x49: `out_enable`=1 gives `w_bus`=Z; `out_enable`=0 gives `w_bus`=0x49; during a later MUL, `w_bus` stays 0x49 until completion.
